// File: rtl/lynx_bfm_pkg.sv
// lynx_bfm_pkg: sink FSM state type and flit field-position helpers shared with the traffic generator
package lynx_bfm_pkg;

    typedef enum logic [1:0] {INIT, RUN, STALL} sink_state_t;

    function automatic int src_lsb(input int width, input int aw);
        return width - aw;
    endfunction

    function automatic int dst_lsb(input int width, input int aw);
        return width - 2 * aw;
    endfunction

    function automatic int id_lsb(input int width, input int aw);
        return width - 2 * aw - 8;
    endfunction

    function automatic int payload_width(input int width, input int aw);
        return width - 2 * aw - 8;
    endfunction

endpackage

// File: rtl/sink_checker_if.sv
// sink_checker_if: flit valid/ready handshake bundle between a traffic source and a sink
interface sink_checker_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] data_in;
    logic             valid_in;
    logic             ready_out;

    modport master (output data_in, output valid_in, input ready_out);
    modport slave  (input data_in, input valid_in, output ready_out);
endinterface

// File: rtl/lfsr8.sv
// lfsr8: seeded 8-bit Galois LFSR (x^8+x^6+x^5+x^4+1) advancing when enabled
module lfsr8 #(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    output logic [7:0] value
);

    // shift right and fold the taps in whenever the output bit is set
    always_ff @(posedge clk) begin
        if (rst) value <= SEED;
        else if (en) value <= {1'b0, value[7:1]} ^ (value[0] ? 8'hB8 : 8'h00);
    end

endmodule

// File: rtl/sink_checker.sv
// sink_checker: NoC sink that counts flits, checks per-source payload sequence and routing; SINK_STALL_EN adds random back-pressure
module sink_checker
    import lynx_bfm_pkg::*;
#(
    parameter int                      WIDTH        = 32,
    parameter int                      N            = 16,
    parameter int                      N_ADDR_WIDTH = $clog2(N),
    parameter logic [7:0]              ID           = 8'd0,
    parameter logic [N_ADDR_WIDTH-1:0] NODE         = 15,
    parameter int                      CNT_WIDTH    = 16,
    parameter logic [7:0]              STALL_THRESH = 8'd64,
    parameter int                      STALL_LEN    = 4,
    parameter logic [7:0]              SEED         = 8'hA5
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear,
    sink_checker_if.slave           bus,
    output logic [CNT_WIDTH-1:0]    pkt_count,
    output logic [CNT_WIDTH-1:0]    err_seq_count,
    output logic [CNT_WIDTH-1:0]    err_dst_count,
    output logic                    err_flag,
    output logic [N_ADDR_WIDTH-1:0] last_src
);

    localparam int DATA_W  = payload_width(WIDTH, N_ADDR_WIDTH);
    localparam int SRC_LSB = src_lsb(WIDTH, N_ADDR_WIDTH);
    localparam int DST_LSB = dst_lsb(WIDTH, N_ADDR_WIDTH);
    localparam int ID_LSB  = id_lsb(WIDTH, N_ADDR_WIDTH);

    sink_state_t             state, state_d;
    logic                    ready_q;
    logic                    accept, seq_err, dst_err;
    logic [N_ADDR_WIDTH-1:0] src, dst;
    logic [7:0]              id_unused;
    logic [DATA_W-1:0]       payload;
    logic [N-1:0]            seen;
    logic [DATA_W-1:0]       exp_tab [N];

    assign src           = bus.data_in[SRC_LSB +: N_ADDR_WIDTH];
    assign dst           = bus.data_in[DST_LSB +: N_ADDR_WIDTH];
    assign id_unused     = bus.data_in[ID_LSB +: 8];
    assign payload       = bus.data_in[DATA_W-1:0];
    assign bus.ready_out = ready_q;
    assign accept        = bus.valid_in && ready_q;
    assign seq_err       = seen[src] && (payload != exp_tab[src]);
    assign dst_err       = dst != NODE;

`ifdef SINK_STALL_EN
    localparam int SC_W = $clog2(STALL_LEN) + 1;

    logic [7:0]      lfsr_val;
    logic [SC_W-1:0] stall_cnt, stall_cnt_d;
    logic [7:0]      id_param_unused;

    assign id_param_unused = ID;

    lfsr8 #(.SEED(SEED)) u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .en    (state == RUN),
        .value (lfsr_val)
    );

    // next state: random entry into STALL from RUN, leave after STALL_LEN cycles
    always_comb begin
        state_d     = state == INIT ? RUN :
                      state == RUN  ? (lfsr_val < STALL_THRESH ? STALL : RUN) :
                      (stall_cnt == '0 ? RUN : STALL);
        stall_cnt_d = state == RUN   ? SC_W'(STALL_LEN - 1) :
                      state == STALL ? stall_cnt - 1'b1 : '0;
    end

    // remaining stall cycles
    always_ff @(posedge clk) begin
        stall_cnt <= rst ? '0 : stall_cnt_d;
    end
`else
    logic [7:0] cfg_unused;

    assign cfg_unused = ID ^ STALL_THRESH ^ SEED ^ 8'(STALL_LEN);

    // next state: leave INIT and stay in RUN
    always_comb begin
        state_d = state == INIT ? RUN : state;
    end
`endif

    // state register; ready is registered from the next state so it lines up with RUN
    always_ff @(posedge clk) begin
        state   <= rst ? INIT : state_d;
        ready_q <= !rst && state_d == RUN;
    end

    // statistics: clear beats a same-edge acceptance, counters saturate
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            pkt_count     <= '0;
            err_seq_count <= '0;
            err_dst_count <= '0;
            err_flag      <= 1'b0;
            last_src      <= '0;
            seen          <= '0;
        end else if (accept) begin
            pkt_count     <= pkt_count + CNT_WIDTH'(pkt_count != '1);
            err_seq_count <= err_seq_count + CNT_WIDTH'(seq_err && err_seq_count != '1);
            err_dst_count <= err_dst_count + CNT_WIDTH'(dst_err && err_dst_count != '1);
            err_flag      <= err_flag || seq_err || dst_err;
            last_src      <= src;
            seen[src]     <= 1'b1;
        end
    end

    // expected next payload per source; only meaningful while its seen bit is set
    always_ff @(posedge clk) begin
        if (accept && !rst) exp_tab[src] <= payload + DATA_W'(1);
    end

endmodule

// File: tb/tb_sink_checker.sv
// tb_sink_checker: scoreboard bench for sink_checker (main instance plus a 4-bit counter instance)
module tb_sink_checker;

    localparam int SL = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic clear = 1'b0;
    logic sclear = 1'b0;

    always #5 clk = ~clk;

    sink_checker_if #(.WIDTH(32)) bus ();
    sink_checker_if #(.WIDTH(32)) sbus ();

    logic [15:0] pkt, seq, dst;
    logic        flag;
    logic [3:0]  last;
    logic [3:0]  s_pkt, s_seq, s_dst, s_last;
    logic        s_flag;

    sink_checker #(.STALL_THRESH(8'd128), .STALL_LEN(SL)) dut (
        .clk(clk), .rst(rst), .clear(clear), .bus(bus),
        .pkt_count(pkt), .err_seq_count(seq), .err_dst_count(dst),
        .err_flag(flag), .last_src(last)
    );

    sink_checker #(.CNT_WIDTH(4)) sdut (
        .clk(clk), .rst(rst), .clear(sclear), .bus(sbus),
        .pkt_count(s_pkt), .err_seq_count(s_seq), .err_dst_count(s_dst),
        .err_flag(s_flag), .last_src(s_last)
    );

    typedef struct packed {
        logic [15:0] pkt;
        logic [15:0] seq;
        logic [15:0] dst;
        logic        flag;
        logic [3:0]  last;
    } stat_t;

    stat_t      q[$];
    logic [3:0] sq[$];
    int         cmp = 0;
    int         bad = 0;

    logic [15:0] m_seen;
    logic [15:0] m_exp [16];
    logic [15:0] m_pkt, m_seq, m_dst;
    logic        m_flag;
    logic [3:0]  m_last;

    function automatic void model_clear();
        m_seen = '0; m_pkt = '0; m_seq = '0; m_dst = '0; m_flag = 1'b0; m_last = '0;
    endfunction

    function automatic void model_accept(input logic [3:0] s, input logic [3:0] d, input logic [15:0] p);
        if (m_seen[s] && p != m_exp[s]) begin
            if (m_seq != 16'hFFFF) m_seq++;
            m_flag = 1'b1;
        end
        if (d != 4'd15) begin
            if (m_dst != 16'hFFFF) m_dst++;
            m_flag = 1'b1;
        end
        if (m_pkt != 16'hFFFF) m_pkt++;
        m_seen[s] = 1'b1;
        m_exp[s]  = p + 16'd1;
        m_last    = s;
    endfunction

    // drive one flit on the main sink (called at a negedge), then score all statistics
    task automatic send(input logic [3:0] s, input logic [3:0] d, input logic [15:0] p,
                        input logic clr, input string tag);
        int    t = 0;
        stat_t e, got;
        while (bus.ready_out !== 1'b1 && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) begin
            cmp++; bad++;
            $display("FAIL %s ready_out timeout got %b want 1", tag, bus.ready_out);
            return;
        end
        bus.data_in = {s, d, 8'h5A, p};
        bus.valid_in = 1'b1;
        clear = clr;
        @(posedge clk);
        if (clr) model_clear();
        else model_accept(s, d, p);
        q.push_back('{m_pkt, m_seq, m_dst, m_flag, m_last});
        #1;
        e = q.pop_front();
        got = '{pkt, seq, dst, flag, last};
        cmp += 5;
        if (got.pkt !== e.pkt) begin bad++; $display("FAIL %s pkt_count got %0d want %0d", tag, got.pkt, e.pkt); end
        if (got.seq !== e.seq) begin bad++; $display("FAIL %s err_seq_count got %0d want %0d", tag, got.seq, e.seq); end
        if (got.dst !== e.dst) begin bad++; $display("FAIL %s err_dst_count got %0d want %0d", tag, got.dst, e.dst); end
        if (got.flag !== e.flag) begin bad++; $display("FAIL %s err_flag got %b want %b", tag, got.flag, e.flag); end
        if (got.last !== e.last) begin bad++; $display("FAIL %s last_src got %0d want %0d", tag, got.last, e.last); end
        @(negedge clk);
        bus.valid_in = 1'b0;
        clear = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        cmp += 3;
        if (bus.ready_out !== 1'b0) begin bad++; $display("FAIL reset ready_out got %b want 0", bus.ready_out); end
        if ({pkt, seq, dst, flag, last} !== '0) begin bad++; $display("FAIL reset stats got %h want 0", {pkt, seq, dst, flag, last}); end
        if ({s_pkt, s_seq, s_dst, s_flag, s_last} !== '0) begin bad++; $display("FAIL reset small_stats got %h want 0", {s_pkt, s_seq, s_dst, s_flag, s_last}); end
        rst = 1'b0;
        #1;
        cmp++;
        if (bus.ready_out !== 1'b0) begin bad++; $display("FAIL release ready_out got %b want 0", bus.ready_out); end
        @(posedge clk);
        #1;
        cmp++;
        if (bus.ready_out !== 1'b1) begin bad++; $display("FAIL first_run ready_out got %b want 1", bus.ready_out); end
        model_clear();
        @(negedge clk);
    endtask

    task automatic test_sequence();
        send(4'd2, 4'd15, 16'd5, 1'b0, "seq5");
        send(4'd2, 4'd15, 16'd6, 1'b0, "seq6");
        send(4'd2, 4'd15, 16'd7, 1'b0, "seq7");
        cmp += 3;
        if (pkt !== 16'd3) begin bad++; $display("FAIL seq_total pkt_count got %0d want 3", pkt); end
        if (seq !== 16'd0) begin bad++; $display("FAIL seq_total err_seq_count got %0d want 0", seq); end
        if (last !== 4'd2) begin bad++; $display("FAIL seq_total last_src got %0d want 2", last); end
        send(4'd2, 4'd15, 16'd9, 1'b0, "seq9");
        cmp += 2;
        if (seq !== 16'd1) begin bad++; $display("FAIL seq_gap err_seq_count got %0d want 1", seq); end
        if (flag !== 1'b1) begin bad++; $display("FAIL seq_gap err_flag got %b want 1", flag); end
        send(4'd2, 4'd15, 16'd10, 1'b0, "seq10");
        cmp++;
        if (seq !== 16'd1) begin bad++; $display("FAIL seq_resync err_seq_count got %0d want 1", seq); end
    endtask

    task automatic test_wrap_and_dst();
        send(4'd1, 4'd15, 16'hFFFF, 1'b0, "wrap_hi");
        send(4'd1, 4'd15, 16'h0000, 1'b0, "wrap_lo");
        cmp++;
        if (seq !== 16'd1) begin bad++; $display("FAIL wrap err_seq_count got %0d want 1", seq); end
        send(4'd1, 4'd3, 16'h0001, 1'b0, "misroute");
        cmp++;
        if (dst !== 16'd1) begin bad++; $display("FAIL misroute err_dst_count got %0d want 1", dst); end
        send(4'd9, 4'd0, 16'h1234, 1'b0, "first_misroute");
    endtask

    task automatic test_clear();
        send(4'd5, 4'd15, 16'd100, 1'b0, "pre_clear");
        send(4'd5, 4'd15, 16'd200, 1'b1, "clear_edge");
        cmp += 2;
        if (pkt !== 16'd0) begin bad++; $display("FAIL clear pkt_count got %0d want 0", pkt); end
        if (flag !== 1'b0) begin bad++; $display("FAIL clear err_flag got %b want 0", flag); end
        send(4'd5, 4'd15, 16'd500, 1'b0, "post_clear");
        cmp += 2;
        if (seq !== 16'd0) begin bad++; $display("FAIL post_clear err_seq_count got %0d want 0", seq); end
        if (pkt !== 16'd1) begin bad++; $display("FAIL post_clear pkt_count got %0d want 1", pkt); end
    endtask

    task automatic test_rst_mid();
        send(4'd4, 4'd15, 16'd1, 1'b0, "pre_rst");
        bus.data_in = {4'd4, 4'd3, 8'h00, 16'd77};
        bus.valid_in = 1'b1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        cmp += 3;
        if (pkt !== 16'd0) begin bad++; $display("FAIL rst_mid pkt_count got %0d want 0", pkt); end
        if (dst !== 16'd0) begin bad++; $display("FAIL rst_mid err_dst_count got %0d want 0", dst); end
        if (bus.ready_out !== 1'b0) begin bad++; $display("FAIL rst_mid ready_out got %b want 0", bus.ready_out); end
        @(negedge clk);
        rst = 1'b0;
        bus.valid_in = 1'b0;
        model_clear();
        send(4'd4, 4'd15, 16'd500, 1'b0, "after_rst");
    endtask

    task automatic test_saturation();
        logic [3:0] e;
        for (int i = 0; i < 20; i++) begin
            int t = 0;
            while (sbus.ready_out !== 1'b1 && t < 100) begin
                @(negedge clk);
                t++;
            end
            if (t >= 100) begin
                cmp++; bad++;
                $display("FAIL sat ready_out timeout got %b want 1", sbus.ready_out);
                return;
            end
            sbus.data_in = {4'd6, 4'd15, 8'h00, 16'(i)};
            sbus.valid_in = 1'b1;
            @(posedge clk);
            sq.push_back(i >= 14 ? 4'hF : 4'(i + 1));
            #1;
            e = sq.pop_front();
            cmp++;
            if (s_pkt !== e) begin bad++; $display("FAIL sat[%0d] pkt_count got %h want %h", i, s_pkt, e); end
            @(negedge clk);
            sbus.valid_in = 1'b0;
        end
        cmp += 2;
        if (s_seq !== 4'd0 || s_dst !== 4'd0) begin bad++; $display("FAIL sat errors got %0d/%0d want 0/0", s_seq, s_dst); end
        if (s_last !== 4'd6) begin bad++; $display("FAIL sat last_src got %0d want 6", s_last); end
    endtask

    task automatic test_stall();
        logic [15:0] pv = 16'd0;
        logic [15:0] base;
        logic [15:0] e;
        logic        r;
        int          low = 0;
        int          runs = 0;
        int          hs = 0;
        base = m_pkt;
        bus.data_in = {4'd7, 4'd15, 8'h00, pv};
        bus.valid_in = 1'b1;
        for (int c = 0; c < 1000; c++) begin
            r = bus.ready_out;
            if (!r) low++;
            else if (low > 0) begin
                cmp++; runs++;
                if (low != SL) begin bad++; $display("FAIL stall_run length got %0d want %0d", low, SL); end
                low = 0;
            end
            @(posedge clk);
            if (r) begin
                model_accept(4'd7, 4'd15, pv);
                hs++;
            end
            q.push_back('{m_pkt, m_seq, m_dst, m_flag, m_last});
            #1;
            e = q.pop_front().pkt;
            cmp++;
            if (pkt !== e) begin bad++; $display("FAIL stall_cycle[%0d] pkt_count got %0d want %0d", c, pkt, e); end
            @(negedge clk);
            if (r) begin
                pv++;
                bus.data_in = {4'd7, 4'd15, 8'h00, pv};
            end
        end
        bus.valid_in = 1'b0;
        cmp += 2;
        if (pkt !== 16'(base + 16'(hs))) begin bad++; $display("FAIL stall_total pkt_count got %0d want %0d", pkt, base + 16'(hs)); end
        if (seq !== m_seq) begin bad++; $display("FAIL stall_total err_seq_count got %0d want %0d", seq, m_seq); end
`ifdef SINK_STALL_EN
        cmp++;
        if (runs == 0) begin bad++; $display("FAIL stall_seen runs got 0 want >0"); end
`endif
    endtask

    initial begin
        bus.data_in = '0;
        bus.valid_in = 1'b0;
        sbus.data_in = '0;
        sbus.valid_in = 1'b0;
        for (int i = 0; i < 16; i++) m_exp[i] = '0;
        model_clear();
        test_reset();
        test_sequence();
        test_wrap_and_dst();
        test_clear();
        test_rst_mid();
        test_saturation();
        test_stall();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
        $finish;
    end

endmodule
